// File: rtl/wmul_pipe.sv
// Pipelined SIMD widening multiplier: even/odd element pairs, signed/unsigned, w8/w16/w32.
// Stage 0 holds the captured operation, stage 1 holds the products, later stages only delay.
module wmul_pipe #(
  parameter int DATA_W = 128,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_a,
  input  logic [0:DATA_W-1] in_b,
  input  logic [0:1]        in_ww,
  input  logic [0:1]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_res,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and in_ready depends only on out_valid/out_ready.

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_err;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [0:DATA_W-1] r_res [1:STAGES-1];
  logic [0:DATA_W-1] r_a;
  logic [0:DATA_W-1] r_b;
  logic [0:1]        r_ww;
  logic [0:1]        r_op;

  logic              w_stall;
  logic              w_adv;
  logic [0:DATA_W-1] w_prod;

  // Operands are extended to twice their width; the truncated product is then exact
  // for both signed and unsigned interpretations.
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b,
                                       input logic s);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = {{8{s & a[7]}}, a};
    eb = {{8{s & b[7]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = {{16{s & a[15]}}, a};
    eb = {{16{s & b[15]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{s & a[31]}}, a};
    eb = {{32{s & b[31]}}, b};
    return ea * eb;
  endfunction

  assign w_stall   = out_valid && !out_ready;
  assign w_adv     = !w_stall;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld[STAGES-1];
  assign out_res   = r_res[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_err   = r_err[STAGES-1];

  // r_op[0] selects odd elements, r_op[1] selects signed arithmetic.
  always_comb begin
    w_prod = '0;
    case (r_ww)
      2'b00: for (int k = 0; k < DATA_W/16; k++)
        w_prod[16*k +: 16] = mul8(r_op[0] ? r_a[16*k+8 +: 8] : r_a[16*k +: 8],
                                  r_op[0] ? r_b[16*k+8 +: 8] : r_b[16*k +: 8], r_op[1]);
      2'b01: for (int k = 0; k < DATA_W/32; k++)
        w_prod[32*k +: 32] = mul16(r_op[0] ? r_a[32*k+16 +: 16] : r_a[32*k +: 16],
                                   r_op[0] ? r_b[32*k+16 +: 16] : r_b[32*k +: 16], r_op[1]);
      2'b10: for (int k = 0; k < DATA_W/64; k++)
        w_prod[64*k +: 64] = mul32(r_op[0] ? r_a[64*k+32 +: 32] : r_a[64*k +: 32],
                                   r_op[0] ? r_b[64*k+32 +: 32] : r_b[64*k +: 32], r_op[1]);
      default: w_prod = '0;
    endcase
  end

  // The whole pipeline advances or holds together; bubbles are never squeezed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_err <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_ww  <= '0;
      r_op  <= '0;
      for (int k = 0; k < STAGES; k++) r_tag[k] <= '0;
      for (int k = 1; k < STAGES; k++) r_res[k] <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[STAGES-2:0], in_valid};
      if (in_valid) begin
        r_a      <= in_a;
        r_b      <= in_b;
        r_ww     <= in_ww;
        r_op     <= in_op;
        r_tag[0] <= in_tag;
        r_err[0] <= &in_ww;
      end
      r_res[1] <= w_prod;
      for (int k = 1; k < STAGES; k++) begin
        r_tag[k] <= r_tag[k-1];
        r_err[k] <= r_err[k-1];
      end
      for (int k = 2; k < STAGES; k++) r_res[k] <= r_res[k-1];
    end
  end

endmodule

// File: tb/tb_wmul_pipe.sv
// Directed bench for wmul_pipe: per-feature tasks with hand-computed vectors.
module tb_wmul_pipe;
  localparam int DATA_W = 128;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [0:DATA_W-1] in_a = '0;
  logic [0:DATA_W-1] in_b = '0;
  logic [0:1]        in_ww = '0;
  logic [0:1]        in_op = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [0:DATA_W-1] out_res;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  int checks = 0;
  int failures = 0;

  logic [0:DATA_W-1] va [6];
  logic [0:DATA_W-1] vb [6];
  logic [0:DATA_W-1] vr [6];
  logic [0:1]        vww [6];
  logic [0:1]        vop [6];
  logic              verr [6];

  logic [DATA_W-1:0] exp_q[$];
  logic [TAG_W-1:0]  exp_tag_q[$];
  logic              exp_err_q[$];

  wmul_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ww(in_ww), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic init_vectors();
    va[0] = 128'h0402030405060708f00a0b0cff0eff00;
    vb[0] = 128'h03010202030303031004f505ff09fe10;
    vr[0] = 128'h000c0006000f00150f000a87fe01fd02;
    vww[0] = 2'b00; vop[0] = 2'b00; verr[0] = 1'b0;
    va[1] = 128'h0001000200000008000f10bff103ffff;
    vb[1] = 128'h0002000400060008000c001000120014;
    vr[1] = 128'h000000080000004000010bf00013ffec;
    vww[1] = 2'b01; vop[1] = 2'b10; verr[1] = 1'b0;
    va[2] = 128'h0180010501f9015301040100013c0100;
    vb[2] = 128'h017f010901fa010001fd01f101b80100;
    vr[2] = 128'hc080002d002a0000fff40000ef200000;
    vww[2] = 2'b00; vop[2] = 2'b11; verr[2] = 1'b0;
    va[3] = 128'h1111000211118000111120541111fff9;
    vb[3] = 128'hffff0004ffff7fffffff0000fffffffd;
    vr[3] = 128'h00000008c00080000000000000000015;
    vww[3] = 2'b01; vop[3] = 2'b11; verr[3] = 1'b0;
    va[4] = 128'h80000000000000000000000300000000;
    vb[4] = 128'h7fffffff00000000fffffffe00000000;
    vr[4] = 128'hc000000080000000fffffffffffffffa;
    vww[4] = 2'b10; vop[4] = 2'b01; verr[4] = 1'b0;
    va[5] = 128'h0402030405060708f00a0b0cff0eff00;
    vb[5] = 128'h03010202030303031004f505ff09fe10;
    vr[5] = '0;
    vww[5] = 2'b11; vop[5] = 2'b00; verr[5] = 1'b1;
  endtask

  task automatic drive_op(input int idx, input logic [TAG_W-1:0] tag);
    in_a = va[idx]; in_b = vb[idx]; in_ww = vww[idx]; in_op = vop[idx]; in_tag = tag;
  endtask

  // Issues one op, then counts edges after acceptance until out_valid (bounded).
  task automatic send_and_wait(input int idx, input logic [TAG_W-1:0] tag, output int lat);
    int guard;
    @(negedge clk);
    drive_op(idx, tag);
    in_valid = 1'b1;
    guard = 0;
    #2;
    while (!in_ready && guard < 20) begin
      @(negedge clk); #2; guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_tag !== '0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b res=%h tag=%h err=%b exp all zero",
               out_valid, out_res, out_tag, out_err);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single(input string name, input int idx, input logic [TAG_W-1:0] tag);
    int lat;
    out_ready = 1'b1;
    send_and_wait(idx, tag, lat);
    checks++;
    if (out_valid !== 1'b1 || lat !== STAGES-1) begin
      failures++;
      $display("FAIL %s_latency got v=%b edges=%0d exp v=1 edges=%0d", name, out_valid, lat, STAGES-1);
    end
    checks++;
    if (out_res !== vr[idx]) begin
      failures++; $display("FAIL %s_res got=%h exp=%h", name, out_res, vr[idx]);
    end
    checks++;
    if (out_tag !== tag) begin
      failures++; $display("FAIL %s_tag got=%h exp=%h", name, out_tag, tag);
    end
    checks++;
    if (out_err !== verr[idx]) begin
      failures++; $display("FAIL %s_err got=%b exp=%b", name, out_err, verr[idx]);
    end
  endtask

  task automatic test_w8_even_unsigned();  test_single("w8_even_u", 0, 5'd1);  endtask
  task automatic test_w16_odd_unsigned();  test_single("w16_odd_u", 1, 5'd2);  endtask
  task automatic test_w8_odd_signed();     test_single("w8_odd_s", 2, 5'd3);   endtask
  task automatic test_w16_odd_signed();    test_single("w16_odd_s", 3, 5'd4);  endtask
  task automatic test_w32_even_signed();   test_single("w32_even_s", 4, 5'd5); endtask
  task automatic test_reserved_width();    test_single("reserved", 5, 5'd22);  endtask

  task automatic test_back_to_back();
    int rcv = 0;
    int stall_cnt = 0;
    logic [DATA_W-1:0] er;
    logic [TAG_W-1:0]  et;
    logic              ee;
    @(negedge clk);
    fork
      begin : driver
        int i = 0;
        int cyc = 0;
        while (i < 8 && cyc < 100) begin
          @(negedge clk);
          drive_op(i % 6, TAG_W'(i));
          in_valid = 1'b1;
          #2;
          if (in_ready) begin
            exp_q.push_back(vr[i % 6]);
            exp_tag_q.push_back(TAG_W'(i));
            exp_err_q.push_back(verr[i % 6]);
            i++;
          end
          cyc++;
        end
        @(negedge clk) in_valid = 1'b0;
      end
      begin : monitor
        int cyc = 0;
        while (rcv < 8 && cyc < 200) begin
          @(negedge clk);
          out_ready = !(rcv == 2 && stall_cnt < 4);
          #1;
          if (!out_ready) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
              failures++;
              $display("FAIL stall_ctrl got v=%b in_ready=%b exp v=1 in_ready=0", out_valid, in_ready);
            end
            if (exp_q.size() > 0) begin
              checks++;
              if (out_res !== exp_q[0] || out_tag !== exp_tag_q[0]) begin
                failures++;
                $display("FAIL stall_hold got res=%h tag=%h exp res=%h tag=%h",
                         out_res, out_tag, exp_q[0], exp_tag_q[0]);
              end
            end
            stall_cnt++;
          end else if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL stream_extra got tag=%h exp none", out_tag);
            end else begin
              er = exp_q.pop_front(); et = exp_tag_q.pop_front(); ee = exp_err_q.pop_front();
              if (out_res !== er || out_tag !== et || out_err !== ee) begin
                failures++;
                $display("FAIL stream_result got res=%h tag=%h err=%b exp res=%h tag=%h err=%b",
                         out_res, out_tag, out_err, er, et, ee);
              end
            end
            rcv++;
          end
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (rcv !== 8 || stall_cnt !== 4) begin
      failures++; $display("FAIL stream_count got rcv=%0d stalls=%0d exp rcv=8 stalls=4", rcv, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_flight();
    int guard = 0;
    bit seen = 0;
    out_ready = 1'b0;
    @(negedge clk);
    drive_op(0, 5'd12); in_valid = 1'b1;
    @(negedge clk);
    drive_op(1, 5'd13);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && guard < 20) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_flight_fill got v=%b exp=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_tag !== '0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got v=%b res=%h tag=%h err=%b exp all zero",
               out_valid, out_res, out_tag, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_single("post_reset", 1, 5'd9);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL rst_no_replay got extra out_valid exp none");
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_w8_even_unsigned();
    test_w16_odd_unsigned();
    test_w8_odd_signed();
    test_w16_odd_signed();
    test_w32_even_signed();
    test_reserved_width();
    test_back_to_back();
    test_reset_mid_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
